// File: rtl/operand_capture_pkg.sv
// Shared types and defaults for the operand_capture front end.
// The debouncer is built only when OPERAND_CAPTURE_DEBOUNCE_EN is defined.
package operand_capture_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    A_ONLY = 2'd1,
    PAIR   = 2'd2
  } state_e;

  // 1 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 100000;
  localparam int unsigned WIDTH_DEFAULT           = 8;

endpackage

// File: rtl/btn_debounce.sv
// One raw button in, one single-cycle press pulse out: 2-flop synchroniser,
// debouncer (only with OPERAND_CAPTURE_DEBOUNCE_EN) and rising-edge detector.
module btn_debounce
  import operand_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       level;
  logic       level_q;
  logic       pulse_q;

`ifdef OPERAND_CAPTURE_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign level = db_q;
`else
  // Fast-simulation build: the synchronised level feeds the edge detector directly.
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = (DEBOUNCE_CYCLES > 0);
  assign level = sync_q[1];
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level;
      pulse_q <= level & ~level_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/operand_capture.sv
// Latches the switch value into operand A/B on debounced button presses and
// flags a complete pair. Debouncing is enabled by OPERAND_CAPTURE_DEBOUNCE_EN.
module operand_capture
  import operand_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned WIDTH           = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_a,
  input  logic             btn_b,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic             a_loaded,
  output logic             pair_upd
);

  logic p_a, p_b, p_clr;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
    .clk(clk), .rst_n(reset), .btn_i(btn_a), .pulse_o(p_a)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
    .clk(clk), .rst_n(reset), .btn_i(btn_b), .pulse_o(p_b)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
    .clk(clk), .rst_n(reset), .btn_i(btn_clr), .pulse_o(p_clr)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             pair_upd_q, pair_upd_d;

  // Priority clr > a > b; a losing pulse is simply dropped.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    pair_upd_d = 1'b0;
    if (p_clr) begin
      a_d     = '0;
      b_d     = '0;
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (p_a) begin
            a_d     = sw;
            state_d = A_ONLY;
          end
        end
        A_ONLY: begin
          if (p_a) begin
            a_d = sw;
          end else if (p_b) begin
            b_d        = sw;
            state_d    = PAIR;
            pair_upd_d = 1'b1;
          end
        end
        PAIR: begin
          // A new A starts a fresh pair, so the stale B is discarded.
          if (p_a) begin
            a_d     = sw;
            b_d     = '0;
            state_d = A_ONLY;
          end else if (p_b) begin
            b_d        = sw;
            pair_upd_d = 1'b1;
          end
        end
        default: begin
          a_d     = '0;
          b_d     = '0;
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      a_q        <= '0;
      b_q        <= '0;
      pair_upd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pair_upd_q <= pair_upd_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign valid    = (state_q == PAIR);
  assign a_loaded = (state_q != EMPTY);
  assign pair_upd = pair_upd_q;

endmodule

// File: doc/operand_capture.md
# operand_capture

Front-end stage that turns the board's 8 slide switches and three push buttons into the two 8-bit operands consumed by the 8-bit adder/FND display path. Each button is synchronised, debounced and edge-detected. A small state machine then latches the switch value into operand A or operand B and flags when a complete pair is present. Outputs drive the adder's `a`/`b` inputs directly and hold steady between button presses.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles (1 ms at 100 MHz) required before a button level change is accepted; legal range ≥ 2.
- `WIDTH`, default 8: operand and switch width.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sw`  in  WIDTH  raw slide-switch value; quasi-static, sampled only on a load.
- `btn_a`  in  1  raw button, load operand A.
- `btn_b`  in  1  raw button, load operand B.
- `btn_clr`  in  1  raw button, clear both operands.
- `a`  out  WIDTH  operand A to adder.
- `b`  out  WIDTH  operand B to adder.
- `valid`  out  1  high while both operands are loaded.
- `a_loaded`  out  1  high while A holds a user value (LED).
- `pair_upd`  out  1  one-cycle pulse whenever the pair becomes or stays complete with a new value.

## Operation
- Per button: a 2-flop synchroniser, then a debouncer, then a rising-edge detector. The edge detector produces a 1-cycle pulse: `p_a`, `p_b` or `p_clr`.
- Debouncer:
  - Counter clears whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments.
  - On reaching DEBOUNCE_CYCLES−1 the debounced level flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- FSM states: EMPTY, A_ONLY, PAIR. Per-cycle priority is `p_clr` > `p_a` > `p_b`; lower-priority pulses in the same cycle are dropped, not queued.
- EMPTY:
  - `p_a`: a←sw, go to A_ONLY.
  - `p_b`: ignored.
- A_ONLY:
  - `p_a`: a←sw, stay.
  - `p_b`: b←sw, go to PAIR, pulse `pair_upd`.
- PAIR:
  - `p_a`: a←sw, b←0, go to A_ONLY. This starts a new pair.
  - `p_b`: b←sw, stay, pulse `pair_upd`.
- Any state, on `p_clr`: a←0, b←0, go to EMPTY.
- `valid` = (state==PAIR). `a_loaded` = (state≠EMPTY).
- A held button produces exactly one pulse. A release produces no pulse.

## Timing
- Reset values: a=0, b=0, valid=0, a_loaded=0, pair_upd=0, state=EMPTY. Synchroniser flops, debounced levels and edge registers are all 0, and counters are 0.
- Reset assertion takes effect immediately (asynchronous). Any partially-counted debounce is discarded.
- A button held high through reset release is seen as a new press: one pulse after full debounce.
- Latency, from the first clock edge sampling a clean high button to the operand visible on `a`/`b`: 2 (sync) + DEBOUNCE_CYCLES (debounce) + 1 (edge pulse) + 1 (register load) cycles.
- `pair_upd`, `valid` and `a_loaded` change on the same edge as the operand registers.
- Bounce shorter than DEBOUNCE_CYCLES cycles restarts the counter and never produces a pulse.

## Configuration
- Macro `OPERAND_CAPTURE_DEBOUNCE_EN`:
  - Defined: the debouncer is built as described.
  - Undefined: the debouncer is omitted. The edge detector takes the synchroniser output directly, latency becomes 2+1+1 cycles, and DEBOUNCE_CYCLES is unused. This mode is for fast simulation only.
- Synthesis builds define the macro.

## Structure
- Package `operand_capture_pkg`:
  - State enum (EMPTY, A_ONLY, PAIR), 2 bits.
  - Default DEBOUNCE_CYCLES constant.
  - WIDTH default.
- Sub-module `btn_debounce`: synchroniser + debouncer + edge detector, one bit in and one pulse out, parameterised by DEBOUNCE_CYCLES. It is instantiated three times.
- The top level holds only the FSM and the operand registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 with the macro defined.
- Reset, then idle → a=0, b=0, valid=0, a_loaded=0; `p_b` while EMPTY leaves b=0 and state EMPTY.
- sw=0x12, press btn_a; sw=0x34, press btn_b → a=0x12, b=0x34, valid=1, exactly one `pair_upd` pulse.
- btn_a toggled with high pulses of 2 cycles (bouncing) → no load. Then held 10 cycles → one load, and exactly 8 cycles from first clean sample to `a` update.
- In PAIR, sw=0xFF, press btn_a → a=0xFF, b=0, valid=0, state A_ONLY.
- btn_a and btn_clr debounced pulses in the same cycle → a=0, b=0, EMPTY.
- Drop reset mid-debounce of btn_b, then release with the button still high → outputs 0 during reset. After release the A_ONLY/EMPTY rules apply, with one pulse after full latency.
